key_matrix_scan: RTL and testbench
==================================

KEY_MATRIX_SCAN -- requirements
Module: key_matrix_scan

Interface
REQ-001 Parameter ROWS, default 4: number of matrix rows driven by the block; range 1..8.
REQ-002 Parameter COLS, default 4: number of matrix columns sensed; range 1..8; ROWS*COLS SHALL be 127 or less.
REQ-003 Parameter TICK_DIV, default 50000: clk cycles per row-scan tick; minimum SETTLE+2.
REQ-004 Parameter SETTLE, default 16: clk cycles between driving a row and sampling the columns.
REQ-005 Parameter DEB_N, default 3: consecutive differing frames required to accept a key change; range 1..7.
REQ-006 Parameter FIFO_DEPTH, default 8: depth of the event FIFO; power of 2, 2..64.
REQ-007 clk  in  1  single system clock; all logic is on the rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 row_oe  out  ROWS  1 = drive that row low; 0 = release (tristated at top level).
REQ-010 col_in  in  COLS  column levels, pulled up; low = key on the driven row pressed; externally synchronised.
REQ-011 cs  in  1  bus chip select.
REQ-012 rd  in  1  single-cycle read strobe, qualified by cs.
REQ-013 addr  in  1  0 = event data (pop); 1 = status.
REQ-014 rddat  out  8  read data; 8'h00 when cs=0.
REQ-015 irq  out  1  registered; high while the FIFO is non-empty.

Function
REQ-016 A free-running tick counter SHALL produce a one-cycle tick every TICK_DIV cycles.
REQ-017 FSM states are IDLE, DRIVE, SAMPLE, EVAL.
REQ-018 IDLE -> DRIVE on tick: row_oe is one-hot on row r; r advances 0..ROWS-1 and wraps to 0.
REQ-019 DRIVE holds for SETTLE cycles, then SAMPLE stores ~col_in into raw[r] in one cycle; raw is 1 = pressed.
REQ-020 SAMPLE -> IDLE if r<ROWS-1; SAMPLE -> EVAL after row ROWS-1, ending a frame.
REQ-021 row_oe SHALL be all-zero in IDLE and EVAL.
REQ-022 EVAL visits key index k=row*COLS+col, one per cycle, k=0..ROWS*COLS-1, then goes to IDLE.
REQ-023 Per key: if raw[k]==stable[k], cnt[k] is cleared; otherwise cnt[k] increments.
REQ-024 When cnt[k] reaches DEB_N: stable[k] toggles, cnt[k] clears, and an event is pushed.
REQ-025 Event code is {stable_new, k[6:0]}: bit7 1 = press, 0 = release.
REQ-026 Ticks arriving outside IDLE SHALL be ignored; the scan never overlaps itself.
REQ-027 FIFO is first-word-fall-through; when empty the head reads 8'hFF (reserved code).
REQ-028 cs&&addr==0: rddat = head; pop on the clock edge where cs&&rd&&addr==0 and the FIFO is non-empty.
REQ-029 Read on empty: returns 8'hFF, no pop, no state change.
REQ-030 cs&&addr==1: rddat = {overflow, 1'b0, count[5:0]}; cs&&rd&&addr==1 clears overflow on that edge.
REQ-031 Push while full with no pop: event dropped, overflow set (sticky).
REQ-032 Push and pop in the same cycle: both performed, count unchanged, including when full.
REQ-033 Overflow set and status-read clear in the same cycle: set wins.
REQ-034 irq SHALL be registered from (count!=0), one cycle after the count changes.

Reset
REQ-035 rst asserted: FSM=IDLE, r=0, tick counter=0, row_oe=0, raw=0, stable=0, cnt=0.
REQ-036 rst asserted: FIFO empty, overflow=0, irq=0.
REQ-037 Reset mid-scan or mid-EVAL: the partial frame and any pending event are discarded; no event is emitted on exit.

Structure
REQ-038 Package key_pkg holds the FSM state enum, EMPTY_CODE=8'hFF and the event-code width (8).
REQ-039 The FIFO is sub-module key_fifo (params WIDTH, DEPTH; push, pop, full, empty, count, head).

Verification (bench params ROWS=4, COLS=4, TICK_DIV=20, SETTLE=4, DEB_N=3, FIFO_DEPTH=4)
REQ-040 Press row1/col2 held 5 frames -> exactly one event 8'h86 after frame 3, irq=1; read addr0 -> 8'h86, irq=0 one cycle later.
REQ-041 Press row1/col2 for 2 frames only (bounce) -> no event; status read returns 8'h00.
REQ-042 Press then release key 0 -> events 8'h80 then 8'h00 in order; a third read returns 8'hFF with no pop.
REQ-043 Six distinct keys pressed in one frame -> 4 events stored; status reads 8'h84; after a status read, overflow reads 0.
REQ-044 FIFO full, and a pop coincides with an EVAL push -> count stays 4, overflow not set, order preserved.
REQ-045 rst pulsed during DRIVE of row 2 while key 5 is held -> all outputs 0 immediately; event 8'h85 reappears only after 3 full frames.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the key matrix scanner: scan FSM states and event-code constants.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    EVAL   = 2'd3
  } state_t;

  localparam int CODE_W = 8;
  localparam logic [CODE_W-1:0] EMPTY_CODE = 8'hFF;

endpackage

// File: rtl/key_fifo.sv
// First-word-fall-through event FIFO; a push while full succeeds only if a pop shares the cycle.
module key_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_matrix_scan.sv
// Row-scanned key matrix with per-key debounce and a readable event FIFO.
// Handshake: a read is the single cycle where cs&&rd; data (addr=0) pops on that edge if non-empty.
module key_matrix_scan
  import key_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int TICK_DIV   = 50000,
  parameter int SETTLE     = 16,
  parameter int DEB_N      = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ROWS-1:0]   row_oe,
  input  logic [COLS-1:0]   col_in,
  input  logic              cs,
  input  logic              rd,
  input  logic              addr,
  output logic [7:0]        rddat,
  output logic              irq,
  output state_t            scan_state
);

  localparam int KEYS = ROWS * COLS;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int KW   = (KEYS > 1) ? $clog2(KEYS) : 1;
  localparam int TW   = $clog2(TICK_DIV);
  localparam int SW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;

  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);
  localparam logic [KW-1:0] KEY_LAST    = KW'(KEYS - 1);
  localparam logic [2:0]    CNT_LAST    = 3'(DEB_N - 1);

  state_t          state;
  state_t          next;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [SW-1:0]   settle_cnt;
  logic [RW-1:0]   row;
  logic [KW-1:0]   key_idx;
  logic [KEYS-1:0] raw;
  logic [KEYS-1:0] stable;
  logic [2:0]      cnt [KEYS];

  logic            cur_raw;
  logic            cur_stable;
  logic [2:0]      cur_cnt;
  logic            push;
  logic [7:0]      code;

  logic            pop;
  logic            full;
  logic            empty;
  logic [CW-1:0]   fifo_count;
  logic [7:0]      head;
  logic [6:0]      count7;
  logic            overflow;

  assign tick       = (tick_cnt == TICK_LAST);
  assign scan_state = state;

  assign cur_raw    = raw[key_idx];
  assign cur_stable = stable[key_idx];
  assign cur_cnt    = cnt[key_idx];
  // The change that completes the debounce count is the one that emits an event.
  assign push       = (state == EVAL) && (cur_raw != cur_stable) && (cur_cnt == CNT_LAST);
  assign code       = {~cur_stable, 7'(key_idx)};

  always_comb begin
    next   = state;
    row_oe = '0;
    case (state)
      IDLE:   if (tick) next = DRIVE;
      DRIVE:  if (settle_cnt == SETTLE_LAST) next = SAMPLE;
      SAMPLE: next = (row == ROW_LAST) ? EVAL : IDLE;
      EVAL:   if (key_idx == KEY_LAST) next = IDLE;
      default: next = IDLE;
    endcase
    if (state == DRIVE || state == SAMPLE) begin
      for (int i = 0; i < ROWS; i++) row_oe[i] = (RW'(i) == row);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      settle_cnt <= '0;
      row        <= '0;
      key_idx    <= '0;
      raw        <= '0;
      stable     <= '0;
      for (int k = 0; k < KEYS; k++) cnt[k] <= '0;
    end else begin
      state    <= next;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      settle_cnt <= (state == DRIVE && next == DRIVE) ? settle_cnt + 1'b1 : '0;
      case (state)
        SAMPLE: begin
          for (int i = 0; i < ROWS; i++) begin
            if (RW'(i) == row) raw[i*COLS +: COLS] <= ~col_in;
          end
          row     <= (row == ROW_LAST) ? '0 : row + 1'b1;
          key_idx <= '0;
        end
        EVAL: begin
          if (cur_raw == cur_stable) begin
            cnt[key_idx] <= '0;
          end else if (cur_cnt == CNT_LAST) begin
            stable[key_idx] <= ~cur_stable;
            cnt[key_idx]    <= '0;
          end else begin
            cnt[key_idx] <= cur_cnt + 3'd1;
          end
          key_idx <= key_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pop = cs && rd && !addr;

  key_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (code),
    .full  (full),
    .empty (empty),
    .count (fifo_count),
    .head  (head)
  );

  // Setting overflow takes priority over a same-cycle status-read clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (push && full && !pop)  overflow <= 1'b1;
      else if (cs && rd && addr) overflow <= 1'b0;
      irq <= (fifo_count != '0);
    end
  end

  assign count7 = 7'(fifo_count);

  always_comb begin
    rddat = 8'h00;
    if (cs) rddat = addr ? {overflow, 1'b0, count7[5:0]} : (empty ? EMPTY_CODE : head);
  end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Directed bench for key_matrix_scan: a matrix model drives col_in, reads are scored from a queue.
module tb_key_matrix_scan;
  import key_pkg::*;

  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int TICK_DIV   = 20;
  localparam int SETTLE     = 4;
  localparam int DEB_N      = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 400;

  logic            clk = 1'b0;
  logic            rst;
  logic [ROWS-1:0] row_oe;
  logic [COLS-1:0] col_in;
  logic            cs;
  logic            rd;
  logic            addr;
  logic [7:0]      rddat;
  logic            irq;
  state_t          scan_state;

  logic [ROWS*COLS-1:0] keys;
  logic [7:0]           exp_q[$];
  int                   n_cmp = 0;
  int                   n_err = 0;
  int                   n_rd  = 0;

  // clock / reset
  always #5 clk = ~clk;

  // Pressed keys pull their column low while their row is driven.
  always_comb begin
    col_in = '1;
    for (int r = 0; r < ROWS; r++) begin
      if (row_oe[r]) col_in = col_in & ~keys[r*COLS +: COLS];
    end
  end

  key_matrix_scan #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .TICK_DIV   (TICK_DIV),
    .SETTLE     (SETTLE),
    .DEB_N      (DEB_N),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_oe     (row_oe),
    .col_in     (col_in),
    .cs         (cs),
    .rd         (rd),
    .addr       (addr),
    .rddat      (rddat),
    .irq        (irq),
    .scan_state (scan_state)
  );

  function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout expected event within %0d cycles", name, TIMEOUT);
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst === 1'b0 && cs && rd) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL read_unexpected: got %h expected no read", rddat);
      end else begin
        check($sformatf("read%0d_addr%0d", n_rd, addr), rddat, exp_q.pop_front());
        n_rd++;
      end
    end
  end

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic a, input logic [7:0] e);
    cs   = 1'b1;
    rd   = 1'b1;
    addr = a;
    exp_q.push_back(e);
    cycle();
    cs   = 1'b0;
    rd   = 1'b0;
    addr = 1'b0;
  endtask

  task automatic wait_eval_start();
    int n = 0;
    while (scan_state != EVAL && n < TIMEOUT) begin
      cycle();
      n++;
    end
    if (n >= TIMEOUT) timeout("wait_eval");
  endtask

  task automatic wait_frames(input int frames);
    for (int f = 0; f < frames; f++) begin
      int n = 0;
      wait_eval_start();
      while (scan_state == EVAL && n < TIMEOUT) begin
        cycle();
        n++;
      end
      if (n >= TIMEOUT) timeout("wait_eval_exit");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    keys = '0;
    cs   = 1'b0;
    rd   = 1'b0;
    addr = 1'b0;
    rst  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_row_oe", 8'(row_oe), 8'h00);
    check("rst_irq", 8'(irq), 8'h00);
    check("rst_state", 8'(scan_state), 8'(IDLE));
    check("rddat_no_cs", rddat, 8'h00);
    rst = 1'b0;
    cycle();
    bus_read(1'b1, 8'h00);
    bus_read(1'b0, 8'hFF);

    // bounce: key 6 held two frames only
    wait_frames(1);
    keys[6] = 1'b1;
    wait_frames(2);
    keys[6] = 1'b0;
    wait_frames(3);
    bus_read(1'b1, 8'h00);
    check("bounce_irq", 8'(irq), 8'h00);

    // key 6 held five frames: one press event after the third
    keys[6] = 1'b1;
    wait_frames(2);
    bus_read(1'b1, 8'h00);
    wait_frames(1);
    bus_read(1'b1, 8'h01);
    check("press_irq", 8'(irq), 8'h01);
    wait_frames(2);
    bus_read(1'b1, 8'h01);
    bus_read(1'b0, 8'h86);
    check("irq_after_pop_edge", 8'(irq), 8'h01);
    cycle();
    check("irq_cleared", 8'(irq), 8'h00);
    keys[6] = 1'b0;
    wait_frames(3);
    bus_read(1'b0, 8'h06);
    bus_read(1'b1, 8'h00);

    // key 0 press then release, then a read on empty
    keys[0] = 1'b1;
    wait_frames(3);
    keys[0] = 1'b0;
    wait_frames(3);
    bus_read(1'b0, 8'h80);
    bus_read(1'b0, 8'h00);
    bus_read(1'b0, 8'hFF);
    bus_read(1'b1, 8'h00);

    // six keys in one frame overflow a four-entry FIFO
    keys[1] = 1'b1; keys[2] = 1'b1; keys[3] = 1'b1;
    keys[4] = 1'b1; keys[9] = 1'b1; keys[15] = 1'b1;
    wait_frames(3);
    bus_read(1'b1, 8'h84);
    bus_read(1'b1, 8'h04);
    bus_read(1'b0, 8'h81);
    bus_read(1'b0, 8'h82);
    bus_read(1'b0, 8'h83);
    bus_read(1'b0, 8'h84);
    bus_read(1'b0, 8'hFF);
    keys = '0;
    wait_frames(3);
    bus_read(1'b1, 8'h84);

    // FIFO full: pop lands on the same cycle as the key-5 push
    keys[5] = 1'b1;
    wait_frames(2);
    wait_eval_start();
    repeat (5) cycle();
    bus_read(1'b0, 8'h01);
    bus_read(1'b1, 8'h04);
    bus_read(1'b0, 8'h02);
    bus_read(1'b0, 8'h03);
    bus_read(1'b0, 8'h04);
    bus_read(1'b1, 8'h01);

    // reset while row 2 is driven, key 5 still held, 8'h85 still queued
    begin
      int n = 0;
      while (row_oe != 4'b0100 && n < TIMEOUT) begin
        cycle();
        n++;
      end
      if (n >= TIMEOUT) timeout("wait_row2");
    end
    rst = 1'b1;
    #1;
    check("midscan_rst_row_oe", 8'(row_oe), 8'h00);
    check("midscan_rst_irq", 8'(irq), 8'h00);
    check("midscan_rst_state", 8'(scan_state), 8'(IDLE));
    cycle();
    rst = 1'b0;
    bus_read(1'b1, 8'h00);
    wait_frames(2);
    bus_read(1'b1, 8'h00);
    wait_frames(1);
    bus_read(1'b1, 8'h01);
    bus_read(1'b0, 8'h85);
    bus_read(1'b0, 8'hFF);

    cycle();
    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
